dp_instr_sequencer: RTL and testbench

// Fetch/decode/execute sequencer that replaces hard-wired test FSMs in front of data_path.

---
 rtl/dp_isa_pkg.sv | 73 +++++++
 rtl/dp_cond_eval.sv | 44 ++++
 rtl/dp_instr_sequencer.sv | 146 ++++++++++++++
 tb/tb_dp_instr_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dp_isa_pkg.sv
// Shared ISA definitions for the datapath sequencer: field encodings, opcodes, condition codes, states.
// Pure declarations; no logic or latency of its own.
// Imported by the sequencer, the condition evaluator and benches.
package dp_isa_pkg;

  // Major opcode field IR[15:12]
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_ADDUI = 4'h6;
  localparam logic [3:0] OP_ADDCI = 4'h7;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // R-type extension field IR[7:4] values with special side effects
  localparam logic [3:0] EXT_NOP = 4'h0;
  localparam logic [3:0] EXT_CMP = 4'hB;
  localparam logic [3:0] EXT_MOV = 4'hD;

  // Datapath opcode constants
  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam logic [7:0] OPC_MOVI = 8'hD0;
  localparam logic [7:0] OPC_CMPI = 8'hB0;

  // Flag vector bit positions
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 3;
  localparam int FLAG_N = 4;

  // Branch condition codes IR[11:8]
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_HI = 4'h4, COND_LS = 4'h5, COND_GT = 4'h6, COND_LE = 4'h7,
    COND_FS = 4'h8, COND_FC = 4'h9, COND_LO = 4'hA, COND_HS = 4'hB,
    COND_LT = 4'hC, COND_GE = 4'hD, COND_UC = 4'hE, COND_NV = 4'hF
  } cond_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Immediate-format major opcodes
  function automatic logic is_imm_op(input logic [3:0] op);
    case (op)
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_ADDUI,
      OP_ADDCI, OP_SUBI, OP_CMPI, OP_MOVI: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // Logical immediates and MOVI take a zero-extended byte; arithmetic ones sign-extend
  function automatic logic imm_is_zext(input logic [3:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_MOVI);
  endfunction

  // Shift extensions whose amount comes from Rsrc rather than the immediate
  function automatic logic shift_uses_reg(input logic [3:0] ext);
    return (ext == 4'h4) || (ext == 4'h6) || (ext == 4'h8) || (ext == 4'h9);
  endfunction

endpackage

// File: rtl/dp_cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the latched flags to taken/not-taken.
// Purely combinational, zero latency.
// No flow control.
module dp_cond_eval
  import dp_isa_pkg::*;
#(
  parameter int FLAG_WIDTH = 5
) (
  input  logic [3:0]            i_cond,
  input  logic [FLAG_WIDTH-1:0] i_flags,
  output logic                  o_take
);

  logic w_c, w_z, w_f, w_l, w_n;
  assign w_c = i_flags[FLAG_C];
  assign w_z = i_flags[FLAG_Z];
  assign w_f = i_flags[FLAG_F];
  assign w_l = i_flags[FLAG_L];
  assign w_n = i_flags[FLAG_N];

  // Decode the condition code against the flag bits
  always_comb begin
    o_take = 1'b0;
    case (i_cond)
      COND_EQ: o_take = w_z;
      COND_NE: o_take = !w_z;
      COND_CS: o_take = w_c;
      COND_CC: o_take = !w_c;
      COND_HI: o_take = w_l;
      COND_LS: o_take = !w_l;
      COND_GT: o_take = w_n;
      COND_LE: o_take = !w_n;
      COND_FS: o_take = w_f;
      COND_FC: o_take = !w_f;
      COND_LO: o_take = !w_l && !w_z;
      COND_HS: o_take = w_l || w_z;
      COND_LT: o_take = !w_n && !w_z;
      COND_GE: o_take = w_n || w_z;
      COND_UC: o_take = 1'b1;
      default: o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_instr_sequencer.sv
// Fetch/decode/execute sequencer driving data_path controls from a synchronous instruction ROM.
// Three cycles per instruction (FETCH, DECODE, EXEC); controls are live only during EXEC.
// No backpressure: ROM must return data the cycle after Imem_rd_en; stops in S_HALT until reset.
module dp_instr_sequencer
  import dp_isa_pkg::*;
#(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5,
  parameter int SEL_WIDTH    = 4,
  parameter int PC_WIDTH     = 8
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Run,
  input  logic [FLAG_WIDTH-1:0]   Flags,
  output logic [PC_WIDTH-1:0]     Imem_addr,
  output logic                    Imem_rd_en,
  input  logic [15:0]             Imem_data,
  output logic [SEL_WIDTH-1:0]    Rsrc_mux_sel,
  output logic [SEL_WIDTH-1:0]    Rdest_mux_sel,
  output logic                    Imm_mux_sel,
  output logic [BIT_WIDTH-1:0]    Imm_val,
  output logic [OPCODE_WIDTH-1:0] Opcode,
  output logic [BIT_WIDTH-1:0]    Reg_File_En,
  output logic                    Halted
);

  state_t                r_state;
  state_t                w_next_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [15:0]           r_ir;
  logic [FLAG_WIDTH-1:0] r_flag_reg;

  logic [3:0]            w_op, w_rd, w_ext, w_rs;
  logic signed [7:0]     w_imm8;
  logic [BIT_WIDTH-1:0]  w_imm_sext, w_imm_zext, w_shamt, w_we_onehot;
  logic [PC_WIDTH-1:0]   w_disp, w_pc_step;
  logic                  w_take, w_flag_upd, w_is_bcond, w_is_halt;

  assign w_op        = r_ir[15:12];
  assign w_rd        = r_ir[11:8];
  assign w_ext       = r_ir[7:4];
  assign w_rs        = r_ir[3:0];
  assign w_imm8      = r_ir[7:0];
  assign w_imm_sext  = BIT_WIDTH'(w_imm8);
  assign w_imm_zext  = BIT_WIDTH'(r_ir[7:0]);
  assign w_shamt     = BIT_WIDTH'(r_ir[3:0]);
  assign w_we_onehot = BIT_WIDTH'(1) << w_rd;
  assign w_disp      = PC_WIDTH'(w_imm8);
  assign w_is_bcond  = (w_op == OP_BCOND);
  assign w_is_halt   = (w_op == OP_HALT);
  // Natural-width add gives the required modulo-2^PC_WIDTH wrap in both directions
  assign w_pc_step   = (w_is_bcond && w_take) ? w_disp : PC_WIDTH'(1);

  // Branches look at the flags latched from the previous flag-setting op
  dp_cond_eval #(
    .FLAG_WIDTH (FLAG_WIDTH)
  ) u_cond_eval (
    .i_cond  (w_rd),
    .i_flags (r_flag_reg),
    .o_take  (w_take)
  );

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Instruction register, program counter and flag register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_pc       <= '0;
      r_ir       <= '0;
      r_flag_reg <= '0;
    end else begin
      if (r_state == S_DECODE) r_ir <= Imem_data;
      if (r_state == S_EXEC) begin
        if (w_flag_upd) r_flag_reg <= Flags;
        if (!w_is_halt) r_pc <= r_pc + w_pc_step;
      end
    end
  end

  // Next state and decoded controls; every control sits at its reset value outside S_EXEC
  always_comb begin
    w_next_state  = r_state;
    Imem_addr     = '0;
    Imem_rd_en    = 1'b0;
    Rsrc_mux_sel  = '0;
    Rdest_mux_sel = '0;
    Imm_mux_sel   = 1'b0;
    Imm_val       = '0;
    Opcode        = OPCODE_WIDTH'(OPC_NOP);
    Reg_File_En   = '0;
    Halted        = 1'b0;
    w_flag_upd    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Run) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        Imem_addr    = r_pc;
        Imem_rd_en   = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_next_state = S_EXEC;
      end
      S_EXEC: begin
        w_next_state = w_is_halt ? S_HALT : S_FETCH;
        if (w_op == OP_RTYPE) begin
          if (w_ext != EXT_NOP) begin
            Rdest_mux_sel = SEL_WIDTH'(w_rd);
            Rsrc_mux_sel  = SEL_WIDTH'(w_rs);
            Opcode        = OPCODE_WIDTH'({4'h0, w_ext});
            Reg_File_En   = (w_ext == EXT_CMP) ? '0 : w_we_onehot;
            w_flag_upd    = (w_ext != EXT_MOV);
          end
        end else if (is_imm_op(w_op)) begin
          Rdest_mux_sel = SEL_WIDTH'(w_rd);
          Rsrc_mux_sel  = SEL_WIDTH'(w_rd);
          Opcode        = OPCODE_WIDTH'({w_op, 4'h0});
          Imm_mux_sel   = 1'b1;
          Imm_val       = imm_is_zext(w_op) ? w_imm_zext : w_imm_sext;
          Reg_File_En   = (w_op == OP_CMPI) ? '0 : w_we_onehot;
          w_flag_upd    = (w_op != OP_MOVI);
        end else if (w_op == OP_SHIFT) begin
          Rdest_mux_sel = SEL_WIDTH'(w_rd);
          Rsrc_mux_sel  = SEL_WIDTH'(w_rs);
          Opcode        = OPCODE_WIDTH'({w_op, w_ext});
          Imm_mux_sel   = !shift_uses_reg(w_ext);
          Imm_val       = w_shamt;
          Reg_File_En   = w_we_onehot;
        end
        // Bcond, HALT and undefined majors leave the controls at NOP
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dp_instr_sequencer.sv
// Directed bench: ROM model plus a tiny register-file/ALU stand-in for data_path.
module tb_dp_instr_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Run;
  logic [4:0]  Flags;
  logic [7:0]  Imem_addr;
  logic        Imem_rd_en;
  logic [15:0] Imem_data = 16'h0000;
  logic [3:0]  Rsrc_mux_sel, Rdest_mux_sel;
  logic        Imm_mux_sel;
  logic [15:0] Imm_val;
  logic [7:0]  Opcode;
  logic [15:0] Reg_File_En;
  logic        Halted;

  logic [15:0] rom [0:255];
  logic [15:0] rf  [0:15] = '{default: 16'h0000};
  logic [15:0] opa, opb, res;
  int n_vec = 0;
  int n_err = 0;

  dp_instr_sequencer #(
    .BIT_WIDTH(16), .OPCODE_WIDTH(8), .FLAG_WIDTH(5), .SEL_WIDTH(4), .PC_WIDTH(8)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Flags(Flags),
    .Imem_addr(Imem_addr), .Imem_rd_en(Imem_rd_en), .Imem_data(Imem_data),
    .Rsrc_mux_sel(Rsrc_mux_sel), .Rdest_mux_sel(Rdest_mux_sel),
    .Imm_mux_sel(Imm_mux_sel), .Imm_val(Imm_val), .Opcode(Opcode),
    .Reg_File_En(Reg_File_En), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // Synchronous instruction ROM
  always @(posedge Clk) if (Imem_rd_en) Imem_data <= rom[Imem_addr];

  // Minimal data_path stand-in: enough ops for the program, Z flag from the result
  always_comb begin
    opa = rf[Rdest_mux_sel];
    opb = Imm_mux_sel ? Imm_val : rf[Rsrc_mux_sel];
    case (Opcode)
      8'h05, 8'h50: res = opa + opb;
      8'h09, 8'h90, 8'h0B, 8'hB0: res = opa - opb;
      8'h0D, 8'hD0: res = opb;
      8'h01, 8'h10: res = opa & opb;
      default: res = 16'h0000;
    endcase
    Flags = {3'b000, (res == 16'h0000), 1'b0};
  end

  always @(posedge Clk) begin
    for (int i = 0; i < 16; i++) if (Reg_File_En[i]) rf[i] <= res;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [7:0] opc, input logic [3:0] rd,
                           input logic [3:0] rs, input logic isel, input logic [15:0] ival,
                           input logic [15:0] we);
    check_eq({tag, "_opcode"}, 32'(Opcode), 32'(opc));
    check_eq({tag, "_rdest"},  32'(Rdest_mux_sel), 32'(rd));
    check_eq({tag, "_rsrc"},   32'(Rsrc_mux_sel), 32'(rs));
    check_eq({tag, "_immsel"}, 32'(Imm_mux_sel), 32'(isel));
    check_eq({tag, "_immval"}, 32'(Imm_val), 32'(ival));
    check_eq({tag, "_we"},     32'(Reg_File_En), 32'(we));
  endtask

  task automatic check_nop(input string tag);
    check_ctl(tag, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Wait (bounded) for the next fetch, check its address, then step to that instruction's EXEC
  task automatic to_exec(input logic [7:0] exp_addr, input string tag, output int waits);
    bit seen = 1'b0;
    waits = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      waits++;
      if (Imem_rd_en) seen = 1'b1;
    end
    check_eq({tag, "_fetch_seen"}, 32'(seen), 32'd1);
    if (seen) check_eq({tag, "_addr"}, 32'(Imem_addr), 32'(exp_addr));
    @(negedge Clk);
    check_eq({tag, "_decode_rden"}, 32'(Imem_rd_en), 32'd0);
    @(negedge Clk);
  endtask

  initial begin
    int w;
    Rst = 1'b0;
    Run = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    rom[8'h00] = 16'hD27F;  // MOVI R2,0x7F
    rom[8'h01] = 16'hD101;  // MOVI R1,0x01
    rom[8'h02] = 16'h0251;  // ADD  R2,R1
    rom[8'h03] = 16'h94FF;  // SUBI R4,0xFF
    rom[8'h04] = 16'h15FF;  // ANDI R5,0xFF
    rom[8'h05] = 16'hB400;  // CMPI R4,0 (r4=1)
    rom[8'h06] = 16'hC003;  // BEQ +3, not taken
    rom[8'h07] = 16'hD400;  // MOVI R4,0
    rom[8'h08] = 16'hB400;  // CMPI R4,0 (r4=0)
    rom[8'h09] = 16'hC003;  // BEQ +3, taken to 0x0C
    rom[8'h0C] = 16'h8342;  // shift, register amount
    rom[8'h0D] = 16'h8305;  // shift, immediate amount 5
    rom[8'h0E] = 16'h4123;  // undefined major -> NOP
    rom[8'h0F] = 16'hF000;  // HALT

    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    repeat (10) @(negedge Clk);
    check_eq("idle_rden",   32'(Imem_rd_en), 32'd0);
    check_eq("idle_addr",   32'(Imem_addr), 32'd0);
    check_eq("idle_halted", 32'(Halted), 32'd0);
    check_nop("idle");

    Run = 1'b1;
    to_exec(8'h00, "movi_r2", w);
    check_ctl("movi_r2", 8'hD0, 4'h2, 4'h2, 1'b1, 16'h007F, 16'h0004);
    to_exec(8'h01, "movi_r1", w);
    check_ctl("movi_r1", 8'hD0, 4'h1, 4'h1, 1'b1, 16'h0001, 16'h0002);
    to_exec(8'h02, "add", w);
    check_eq("add_cadence", 32'(w), 32'd1);
    check_ctl("add", 8'h05, 4'h2, 4'h1, 1'b0, 16'h0000, 16'h0004);
    to_exec(8'h03, "subi", w);
    check_eq("add_result_r2", 32'(rf[2]), 32'h0080);
    check_ctl("subi", 8'h90, 4'h4, 4'h4, 1'b1, 16'hFFFF, 16'h0010);
    to_exec(8'h04, "andi", w);
    check_ctl("andi", 8'h10, 4'h5, 4'h5, 1'b1, 16'h00FF, 16'h0020);
    to_exec(8'h05, "cmpi_ne", w);
    check_ctl("cmpi_ne", 8'hB0, 4'h4, 4'h4, 1'b1, 16'h0000, 16'h0000);
    to_exec(8'h06, "beq_nt", w);
    check_nop("beq_nt");
    to_exec(8'h07, "movi_r4", w);
    check_ctl("movi_r4", 8'hD0, 4'h4, 4'h4, 1'b1, 16'h0000, 16'h0010);
    to_exec(8'h08, "cmpi_eq", w);
    check_ctl("cmpi_eq", 8'hB0, 4'h4, 4'h4, 1'b1, 16'h0000, 16'h0000);
    to_exec(8'h09, "beq_t", w);
    check_nop("beq_t");
    to_exec(8'h0C, "shift_reg", w);
    check_ctl("shift_reg", 8'h84, 4'h3, 4'h2, 1'b0, 16'h0002, 16'h0008);
    to_exec(8'h0D, "shift_imm", w);
    check_ctl("shift_imm", 8'h80, 4'h3, 4'h5, 1'b1, 16'h0005, 16'h0008);
    to_exec(8'h0E, "undef", w);
    check_nop("undef");
    to_exec(8'h0F, "halt", w);
    check_nop("halt_exec");
    check_eq("halt_exec_halted", 32'(Halted), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      check_eq("halted",      32'(Halted), 32'd1);
      check_eq("halted_rden", 32'(Imem_rd_en), 32'd0);
      check_eq("halted_we",   32'(Reg_File_En), 32'd0);
    end

    // Second program: backward branch wrap and reset during EXEC
    Rst = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    rom[8'h00] = 16'h0000;  // NOP
    rom[8'h01] = 16'hCEFE;  // BUC -2 -> 0xFF
    rom[8'hFF] = 16'h0251;  // ADD R2,R1 then fall through to 0x00
    @(negedge Clk);
    check_eq("rst_halted", 32'(Halted), 32'd0);
    Rst = 1'b1;
    to_exec(8'h00, "p2_nop", w);
    check_nop("p2_nop");
    to_exec(8'h01, "buc", w);
    check_nop("buc");
    to_exec(8'hFF, "add_ff", w);
    check_ctl("add_ff", 8'h05, 4'h2, 4'h1, 1'b0, 16'h0000, 16'h0004);
    to_exec(8'h00, "wrap", w);
    check_eq("add_ff_result_r2", 32'(rf[2]), 32'h0081);
    to_exec(8'h01, "buc2", w);
    to_exec(8'hFF, "add_rst", w);
    check_eq("add_rst_we_before", 32'(Reg_File_En), 32'h0004);
    #1 Rst = 1'b0;
    #1;
    check_eq("add_rst_we_after",  32'(Reg_File_En), 32'h0000);
    check_eq("add_rst_opcode",    32'(Opcode), 32'h00);
    @(negedge Clk);
    check_eq("add_rst_r2_kept",   32'(rf[2]), 32'h0081);
    check_eq("add_rst_rden",      32'(Imem_rd_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
